// File: rtl/board_pkg.sv
// Shared board-level constants for the NVBoard switch input path.
// Holds the switch count, debounce thresholds for simulation and for the
// FPGA build, and a constant function used to size the debounce counters.
package board_pkg;

   // 8 encoder data switches plus 1 encoder enable switch.
   localparam int SW_WIDTH = 9;

   // Short threshold so simulations see flips within a handful of cycles.
   localparam logic [15:0] DEBOUNCE_CYCLES_SIM = 16'd4;

   // About 1 ms at a 50 MHz board clock, which covers typical contact bounce.
   localparam logic [15:0] DEBOUNCE_CYCLES_FPGA = 16'd50000;

   // Ceiling log2 with a floor of 1, so a counter is never zero bits wide.
   // Used at elaboration time only; the fixed loop bound keeps it
   // acceptable to synthesis tools as a constant function.
   function automatic int clog2(input int value);
      int result;
      result = 1;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage : board_pkg

// File: rtl/sw_debounce_bit.sv
// Single-bit switch conditioner: a two-flop synchroniser, a stability
// counter that must see STABLE_CYCLES consecutive disagreeing samples
// before the clean level flips, and registered rise/fall strobes.
module sw_debounce_bit
   import board_pkg::*;
#(
   parameter logic [15:0] STABLE_CYCLES = DEBOUNCE_CYCLES_FPGA
) (
   input  logic clock,
   input  logic reset,
   input  logic sw_raw,
   output logic sw,
   output logic rise,
   output logic fall
);

   // The counter only has to reach STABLE_CYCLES-1 before it is cleared,
   // so this width always holds the terminal value and cannot saturate.
   localparam int CNT_W = clog2(int'(STABLE_CYCLES) + 1);

   // Count value on which the flip happens. With STABLE_CYCLES=1 this is 0,
   // so the output simply follows the second synchroniser stage one cycle
   // later.
   localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 16'd1);

   logic             sync1;
   logic             sync2;
   logic [CNT_W-1:0] cnt;

   // Synchronise the raw level, time its disagreement with the clean
   // output, and flip the output with a one-cycle strobe at the threshold.
   always_ff @(posedge clock) begin
      // NOTE: every flop, counter included, is cleared on reset so no X can
      // leak into the encoder path; reset also abandons a flip in progress.
      if (reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         cnt   <= '0;
         sw    <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make sync2 take the previous
         // sync1 and the compare below use the previous sync2, giving a
         // true shift register with no logic between stages.
         sync1 <= sw_raw;
         sync2 <= sync1;

         // Strobes default low so they are high for exactly one cycle.
         rise <= 1'b0;
         fall <= 1'b0;

         if (sync2 == sw) begin
            // Input agrees with output: any partial count was a glitch.
            cnt <= '0;
         end else if (cnt == LAST) begin
            // Disagreement held long enough: accept the new level.
            sw   <= sync2;
            cnt  <= '0;
            rise <= sync2;
            fall <= ~sync2;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule : sw_debounce_bit

// File: rtl/sw_debouncer.sv
// Switch input conditioner for the NVBoard top. Each raw switch bit is
// synchronised and debounced independently; the encoder reads io_sw in
// place of the raw pins. io_changed flags any flip on any bit.
module sw_debouncer
   import board_pkg::*;
#(
   parameter int          WIDTH         = SW_WIDTH,
   parameter logic [15:0] STABLE_CYCLES = DEBOUNCE_CYCLES_FPGA
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] io_sw_raw,
   output logic [WIDTH-1:0] io_sw,
   output logic [WIDTH-1:0] io_rise,
   output logic [WIDTH-1:0] io_fall,
   output logic             io_changed
);

   // One fully independent conditioner per switch bit.
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      sw_debounce_bit #(
         .STABLE_CYCLES(STABLE_CYCLES)
      ) u_bit (
         .clock (clock),
         .reset (reset),
         .sw_raw(io_sw_raw[i]),
         .sw    (io_sw[i]),
         .rise  (io_rise[i]),
         .fall  (io_fall[i])
      );
   end

   // The per-bit strobes are already registered one-cycle pulses, so their
   // OR is a single one-cycle pulse even when several bits flip together.
   always_comb begin
      io_changed = |(io_rise | io_fall);
   end

endmodule : sw_debouncer

// File: tb/tb_sw_debouncer.sv
// Directed bench for sw_debouncer with STABLE_CYCLES=4 and WIDTH=9.
// Inputs change on the falling edge; outputs are compared on the falling
// edge after each rising edge.
module tb_sw_debouncer;
   import board_pkg::*;

   localparam int W = SW_WIDTH;

   logic         clock;
   logic         reset;
   logic [W-1:0] io_sw_raw;
   logic [W-1:0] io_sw;
   logic [W-1:0] io_rise;
   logic [W-1:0] io_fall;
   logic         io_changed;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic         rst;
      logic [W-1:0] raw;
      logic [W-1:0] sw;
      logic [W-1:0] rise;
      logic [W-1:0] fall;
      logic         chg;
   } vec_t;

   vec_t tbl[$];

   sw_debouncer #(
      .WIDTH        (W),
      .STABLE_CYCLES(DEBOUNCE_CYCLES_SIM)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .io_sw_raw (io_sw_raw),
      .io_sw     (io_sw),
      .io_rise   (io_rise),
      .io_fall   (io_fall),
      .io_changed(io_changed)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic push(input logic rst, input logic [W-1:0] raw,
                       input logic [W-1:0] sw, input logic [W-1:0] rise,
                       input logic [W-1:0] fall, input logic chg);
      vec_t v;
      v.rst = rst; v.raw = raw; v.sw = sw; v.rise = rise; v.fall = fall; v.chg = chg;
      tbl.push_back(v);
   endtask

   task automatic step();
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic check(input string name, input logic [W-1:0] sw,
                        input logic [W-1:0] rise, input logic [W-1:0] fall,
                        input logic chg);
      checks++;
      if ({io_sw, io_rise, io_fall, io_changed} !== {sw, rise, fall, chg}) begin
         errors++;
         $display("FAIL %s: got sw=%h rise=%h fall=%h chg=%b, expected sw=%h rise=%h fall=%h chg=%b",
                  name, io_sw, io_rise, io_fall, io_changed, sw, rise, fall, chg);
      end
   endtask

   task automatic check_count(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   // Drive a level, wait out the flip, and confirm it settled quietly.
   task automatic settle(input logic [W-1:0] value);
      io_sw_raw = value;
      repeat (7) step();
      check("settle", value, '0, '0, 1'b0);
   endtask

   initial begin
      int rises;
      int falls;
      logic [W-1:0] exp_sw;

      reset     = 1'b1;
      io_sw_raw = 9'h1FF;

      // Reset, power-up rise of all bits, all-fall, clean step, simultaneous.
      repeat (3) push(1, 9'h1FF, 9'h000, 9'h000, 9'h000, 0);
      repeat (5) push(0, 9'h1FF, 9'h000, 9'h000, 9'h000, 0);
      push(0, 9'h1FF, 9'h1FF, 9'h1FF, 9'h000, 1);
      push(0, 9'h1FF, 9'h1FF, 9'h000, 9'h000, 0);
      repeat (5) push(0, 9'h000, 9'h1FF, 9'h000, 9'h000, 0);
      push(0, 9'h000, 9'h000, 9'h000, 9'h1FF, 1);
      push(0, 9'h000, 9'h000, 9'h000, 9'h000, 0);
      repeat (5) push(0, 9'h001, 9'h000, 9'h000, 9'h000, 0);
      push(0, 9'h001, 9'h001, 9'h001, 9'h000, 1);
      push(0, 9'h001, 9'h001, 9'h000, 9'h000, 0);
      repeat (5) push(0, 9'h0F0, 9'h001, 9'h000, 9'h000, 0);
      push(0, 9'h0F0, 9'h0F0, 9'h0F0, 9'h001, 1);
      push(0, 9'h0F0, 9'h0F0, 9'h000, 9'h000, 0);
      repeat (5) push(0, 9'h10F, 9'h0F0, 9'h000, 9'h000, 0);
      push(0, 9'h10F, 9'h10F, 9'h10F, 9'h0F0, 1);
      push(0, 9'h10F, 9'h10F, 9'h000, 9'h000, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         reset     = tbl[i].rst;
         io_sw_raw = tbl[i].raw;
         step();
         check($sformatf("vec%0d", i), tbl[i].sw, tbl[i].rise, tbl[i].fall, tbl[i].chg);
      end

      // Three-cycle glitch on bit 3: never reaches the threshold.
      settle(9'h000);
      for (int e = 0; e < 14; e++) begin
         io_sw_raw = (e < 3) ? 9'h008 : 9'h000;
         step();
         check($sformatf("glitch3_e%0d", e), 9'h000, 9'h000, 9'h000, 1'b0);
      end

      // Four-cycle pulse on bit 3: rises at edge 5, falls at edge 9.
      rises = 0;
      falls = 0;
      for (int e = 0; e < 14; e++) begin
         io_sw_raw = (e < 4) ? 9'h008 : 9'h000;
         step();
         rises += int'(io_rise[3]);
         falls += int'(io_fall[3]);
         check($sformatf("pulse4_e%0d", e),
               (e >= 5 && e <= 8) ? 9'h008 : 9'h000,
               (e == 5) ? 9'h008 : 9'h000,
               (e == 9) ? 9'h008 : 9'h000,
               (e == 5 || e == 9));
      end
      check_count("pulse4_rises", rises, 1);
      check_count("pulse4_falls", falls, 1);

      // Bounce on bit 8: 1,0,1,0,1 then hold; final transition at edge 4.
      settle(9'h000);
      rises = 0;
      for (int e = 0; e < 14; e++) begin
         io_sw_raw = ((e >= 4) || (e % 2 == 0)) ? 9'h100 : 9'h000;
         step();
         rises += int'(io_rise[8]);
         check($sformatf("bounce_e%0d", e),
               (e >= 9) ? 9'h100 : 9'h000,
               (e == 9) ? 9'h100 : 9'h000,
               9'h000, (e == 9));
      end
      check_count("bounce_rises", rises, 1);

      // Reset mid-count on bit 2, then the full latency again.
      settle(9'h000);
      io_sw_raw = 9'h004;
      for (int e = 0; e < 4; e++) begin
         step();
         check($sformatf("midrst_pre_e%0d", e), 9'h000, 9'h000, 9'h000, 1'b0);
      end
      reset = 1'b1;
      step();
      check("midrst_reset", 9'h000, 9'h000, 9'h000, 1'b0);
      reset = 1'b0;
      for (int e = 0; e < 7; e++) begin
         step();
         exp_sw = (e >= 5) ? 9'h004 : 9'h000;
         check($sformatf("midrst_post_e%0d", e), exp_sw,
               (e == 5) ? 9'h004 : 9'h000, 9'h000, (e == 5));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_sw_debouncer

// File: doc/sw_debouncer.md
Name: sw_debouncer

Overview:
- Input conditioner that sits directly upstream of the switch-driven 8-3 encoder / seven-segment path on the NVBoard top.
- Synchronises each raw switch bit into the `clock` domain, then debounces it with a per-bit stability counter.
- Presents clean levels plus single-cycle rise, fall and changed strobes.
- The encoder's `io_in` / `io_en` are then fed from `io_sw` instead of raw pins.

Parameters:
- WIDTH, 9, number of switch bits conditioned (8 data + 1 enable).
- STABLE_CYCLES, 16'd50000, consecutive cycles a synchronised bit must differ from its output before the output flips; legal range ≥1.
- CNT_W, derived = clog2(STABLE_CYCLES+1), width of each per-bit counter.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- io_sw_raw  input  WIDTH  raw asynchronous switch levels.
- io_sw  output  WIDTH  debounced levels.
- io_rise  output  WIDTH  one-cycle pulse per bit when io_sw bit goes 0→1.
- io_fall  output  WIDTH  one-cycle pulse per bit when io_sw bit goes 1→0.
- io_changed  output  1  OR of io_rise|io_fall; one-cycle.

Behaviour:
- Clock and reset: one clock, `clock`; reset is synchronous and active-high, sampled only on the rising edge of `clock`.
- Reset: sync1, sync2, all counters, io_sw, io_rise, io_fall and io_changed go to 0 at the reset edge. Reset mid-count discards progress; no pulse is emitted for a flip aborted by reset.
- Synchroniser: 2 flops per bit (sync1 ← io_sw_raw, sync2 ← sync1). No logic between the stages.
- Per-bit counter rule, evaluated each edge when reset=0:
  - sync2 == io_sw bit → cnt ← 0.
  - sync2 != io_sw bit and cnt == STABLE_CYCLES-1 → io_sw bit ← sync2, cnt ← 0, matching rise/fall bit ← 1.
  - otherwise cnt ← cnt+1.
- Glitches: any return to equality before the threshold clears the counter. Bounce therefore restarts the timing; there is no accumulation across glitches.
- Latency: if io_sw_raw changes and is then held stable before edge k, io_sw updates at edge k+1+STABLE_CYCLES. Total = 2 sync + STABLE_CYCLES-1 counting; exact.
- Strobes: io_rise / io_fall / io_changed are registered and high for exactly the one cycle following the flip edge; they are 0 in all other cycles.
- Bits are fully independent; simultaneous flips on several bits produce simultaneous strobes. io_changed is a single 1-cycle pulse for them.
- Counter saturation is impossible: the counter is cleared at the threshold. CNT_W must hold STABLE_CYCLES-1.
- STABLE_CYCLES=1: the output follows sync2 with one cycle of delay (pure 3-flop path).
- No X-propagation: all state is reset.

Decomposition:
- Shared package `board_pkg`: SW_WIDTH=9, DEBOUNCE_CYCLES_SIM=4, DEBOUNCE_CYCLES_FPGA=50000, and a helper for clog2.
- One sub-module, `sw_debounce_bit`: 1-bit synchroniser + counter + edge detect, parameterised by STABLE_CYCLES.
- The top generates WIDTH instances and ORs the strobes for io_changed.

Test Plan (STABLE_CYCLES=4, WIDTH=9):
- Reset: hold reset=1 for 3 cycles with io_sw_raw=9'h1FF, then release → io_sw=9'h000 and all strobes 0 during reset. io_sw reaches 9'h1FF at edge release+1+4, with io_rise=9'h1FF for one cycle.
- Clean step: io_sw_raw=9'h001 set before edge 10 → io_sw[0]=1 after edge 15; io_rise=9'h001 and io_changed=1 only in cycle 15–16; io_fall stays 0.
- Glitch: io_sw_raw[3] high for 3 cycles then low → io_sw unchanged and no strobes. A 4-cycle pulse (synchronised) → io_sw[3] rises, then falls 4 cycles after the return, with one io_rise and one io_fall pulse.
- Bounce: bit 8 toggles 1,0,1,0,1 on successive cycles, then holds 1 → io_sw[8]=1 exactly 5 edges after the final raw transition's sampling edge; exactly one io_rise[8].
- Simultaneous: io_sw_raw 9'h0F0→9'h10F in one cycle → io_rise=9'h10F and io_fall=9'h0F0 in the same single cycle; io_changed high 1 cycle.
- Reset mid-count: start a 0→1 on bit 2, assert reset at count 2 → io_sw[2]=0 and no pulse. After release with raw still 1, the full 1+4 edge latency applies again.
